// File: rtl/shift_normalizer16.sv
// Sequential leading-one normalizer: one log-shift stage (8,4,2,1) per clock, fixed 5-cycle latency.
// Optional NORM_SIGNED_EN adds a signed_mode input that counts redundant sign bits instead of leading zeros.
module shift_normalizer16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
`ifdef NORM_SIGNED_EN
  input  logic        signed_mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] norm_word,
  output logic [3:0]  shamt,
  output logic        zero
);

  typedef enum logic [2:0] {IDLE, S8, S4, S2, S1, DONE} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_work, w_work_next;
  logic [3:0]  r_shamt, w_shamt_next;
  logic        r_zero, w_zero_next;
  logic        w_signed;
  logic [3:0]  w_k;
  logic [4:0]  w_k1;
  logic [15:0] w_mask_u, w_mask_s, w_sign_diff;
  logic        w_shift_ok;

`ifdef NORM_SIGNED_EN
  logic r_signed, w_signed_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_signed <= 1'b0;
    else     r_signed <= w_signed_next;
  end

  always_comb begin
    w_signed_next = r_signed;
    if (r_state == IDLE && start) w_signed_next = signed_mode;
  end

  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= 16'h0000;
      r_shamt <= 4'd0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_shamt <= w_shamt_next;
      r_zero  <= w_zero_next;
    end
  end

  always_comb begin
    w_k = 4'd0;
    case (r_state)
      S8:      w_k = 4'd8;
      S4:      w_k = 4'd4;
      S2:      w_k = 4'd2;
      S1:      w_k = 4'd1;
      default: w_k = 4'd0;
    endcase
  end

  // Masks select the top k bits (unsigned) or top k+1 bits (signed, compared against bit 15).
  assign w_k1        = {1'b0, w_k} + 5'd1;
  assign w_mask_u    = ~(16'hFFFF >> w_k);
  assign w_mask_s    = ~(16'hFFFF >> w_k1);
  assign w_sign_diff = r_work ^ {16{r_work[15]}};
  assign w_shift_ok  = w_signed ? ((w_sign_diff & w_mask_s) == 16'h0000)
                                : ((r_work & w_mask_u) == 16'h0000);

  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_shamt_next = r_shamt;
    w_zero_next  = r_zero;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = S8;
          w_work_next  = data_in;
          w_shamt_next = 4'd0;
          w_zero_next  = (data_in == 16'h0000);
        end
      end
      S8, S4, S2, S1: begin
        case (r_state)
          S8:      w_state_next = S4;
          S4:      w_state_next = S2;
          S2:      w_state_next = S1;
          default: w_state_next = DONE;
        endcase
        // A zero word would otherwise shift through every stage; it must report shamt=0.
        if (!r_zero && w_shift_ok) begin
          w_work_next  = r_work << w_k;
          w_shamt_next = r_shamt + w_k;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign busy      = (r_state == S8) || (r_state == S4) || (r_state == S2) || (r_state == S1);
  assign done      = (r_state == DONE);
  assign norm_word = r_work;
  assign shamt     = r_shamt;
  assign zero      = r_zero;

endmodule

// File: tb/tb_shift_normalizer16.sv
// Self-checking bench for shift_normalizer16: vector table through a scoreboard, plus
// held-start, async-reset abort and latency sequences.
module tb_shift_normalizer16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        sm;
  logic        busy, done, zero;
  logic [15:0] norm_word;
  logic [3:0]  shamt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  always #5 clk = ~clk;

  shift_normalizer16 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
`ifdef NORM_SIGNED_EN
    .signed_mode(sm),
`endif
    .busy       (busy),
    .done       (done),
    .norm_word  (norm_word),
    .shamt      (shamt),
    .zero       (zero)
  );

  typedef struct {
    logic [15:0] din;
    logic        sm;
    logic [15:0] norm;
    logic [3:0]  sh;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] norm;
    logic [3:0]  sh;
    logic        z;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] norm, input logic [3:0] sh, input logic z);
    exp_t e;
    e.norm = norm; e.sh = sh; e.z = z;
    sb_q.push_back(e);
    n_push++;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_pop++;
        check("sb_norm_word", norm_word, e.norm);
        check("sb_shamt", {12'h0, shamt}, {12'h0, e.sh});
        check("sb_zero", {15'h0, zero}, {15'h0, e.z});
        $display("op %0d: norm_word=%h shamt=%0d zero=%0b", n_pop, norm_word, shamt, zero);
      end
    end
  end

  task automatic run_op(input vec_t v);
    int lat;
    @(negedge clk);
    data_in = v.din;
    sm      = v.sm;
    start   = 1'b1;
    push_exp(v.norm, v.sh, v.z);
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = 16'($urandom);
    check("busy_after_accept", {15'h0, busy}, 16'h1);
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", 16'(lat), 16'd4);
    check("busy_in_done", {15'h0, busy}, 16'h0);
    @(posedge clk); #1;
    check("done_one_cycle", {15'h0, done}, 16'h0);
    check("hold_norm_word", norm_word, v.norm);
    check("hold_shamt", {12'h0, shamt}, {12'h0, v.sh});
  endtask

  function automatic vec_t mk(input logic [15:0] din, input logic s, input logic [15:0] norm,
                              input logic [3:0] sh, input logic z);
    vec_t v;
    v.din = din; v.sm = s; v.norm = norm; v.sh = sh; v.z = z;
    return v;
  endfunction

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 16'h0000;
    sm      = 1'b0;

    vecs.push_back(mk(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0));
    vecs.push_back(mk(16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0));
    vecs.push_back(mk(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0));
    vecs.push_back(mk(16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1));
    vecs.push_back(mk(16'h0300, 1'b0, 16'hC000, 4'd6,  1'b0));
    vecs.push_back(mk(16'h1234, 1'b0, 16'h91A0, 4'd3,  1'b0));
    vecs.push_back(mk(16'h0007, 1'b0, 16'hE000, 4'd13, 1'b0));
    vecs.push_back(mk(16'h4000, 1'b0, 16'h8000, 4'd1,  1'b0));
    vecs.push_back(mk(16'hFFFF, 1'b0, 16'hFFFF, 4'd0,  1'b0));
`ifdef NORM_SIGNED_EN
    vecs.push_back(mk(16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0));
    vecs.push_back(mk(16'h0040, 1'b1, 16'h4000, 4'd8,  1'b0));
    vecs.push_back(mk(16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0));
    vecs.push_back(mk(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1));
    vecs.push_back(mk(16'h8000, 1'b1, 16'h8000, 4'd0,  1'b0));
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_norm_word", norm_word, 16'h0000);
    check("rst_shamt", {12'h0, shamt}, 16'h0);
    check("rst_zero", {15'h0, zero}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // start held high: data_in changes mid-operation and must be ignored until IDLE.
    @(negedge clk);
    sm      = 1'b0;
    data_in = 16'h0300;
    start   = 1'b1;
    push_exp(16'hC000, 4'd6, 1'b0);
    push_exp(16'h8000, 4'd11, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_in = 16'h0010;
    repeat (3) begin @(posedge clk); #1; end
    check("held_first_done", {15'h0, done}, 16'h1);
    @(posedge clk); #1;
    check("held_idle_busy", {15'h0, busy}, 16'h0);
    check("held_idle_done", {15'h0, done}, 16'h0);
    @(posedge clk); #1;
    check("held_restart_busy", {15'h0, busy}, 16'h1);
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("held_second_done", {15'h0, done}, 16'h1);
    @(posedge clk); #1;

    // Asynchronous reset while in S2 aborts without a done pulse.
    @(negedge clk);
    data_in = 16'h00F0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("pre_abort_busy", {15'h0, busy}, 16'h1);
    rst = 1'b1;
    #1;
    check("abort_norm_word", norm_word, 16'h0000);
    check("abort_shamt", {12'h0, shamt}, 16'h0);
    check("abort_zero", {15'h0, zero}, 16'h0);
    check("abort_busy", {15'h0, busy}, 16'h0);
    check("abort_done", {15'h0, done}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    run_op(mk(16'h0400, 1'b0, 16'h8000, 4'd5, 1'b0));

    repeat (3) @(posedge clk);
    check("all_ops_done", 16'(n_pop), 16'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
